// File: rtl/fp_normalize_round.sv
// Post-ALU normalise/round stage: takes a raw significand sum, normalises it
// one bit per cycle, rounds to nearest-even and emits a packed IEEE-754 single.
module fp_normalize_round (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_sig,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        out_overflow,
    output logic        out_zero,
    output logic        out_inexact
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic        r_sign;
    logic [8:0]  r_exp;
    logic [26:0] r_sig;
    logic [31:0] r_out_float;
    logic        r_ovf;
    logic        r_zero;
    logic        r_inx;

    // Exponent is 9 bits wide so a step past 255 shows up as >= 255
    logic [8:0]  w_exp_inc;
    logic        w_round_up;
    logic [24:0] w_m;
    logic [23:0] w_m_n;
    logic [8:0]  w_exp_r;
    logic        w_round_ovf;
    logic [31:0] w_round_float;

    assign w_exp_inc  = r_exp + 9'd1;
    assign w_round_up = r_sig[1] & (r_sig[0] | r_sig[2]);
    assign w_m        = {1'b0, r_sig[25:2]} + {24'd0, w_round_up};
    assign w_m_n      = w_m[24] ? w_m[24:1] : w_m[23:0];
    assign w_exp_r    = r_exp + {8'd0, w_m[24]};
    assign w_round_ovf = (w_exp_r >= 9'd255);
    // Hidden bit clear at exponent 1 means a denormal: encode exponent field 0
    assign w_round_float = w_round_ovf ? {r_sign, 8'hFF, 23'd0}
                         : {r_sign, (w_m_n[23] ? w_exp_r[7:0] : 8'd0), w_m_n[22:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= 9'd0;
            r_sig       <= 27'd0;
            r_out_float <= 32'd0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_inx       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign      <= in_sign;
                        r_exp       <= (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
                        r_sig       <= in_sig;
                        r_out_float <= 32'd0;
                        r_ovf       <= 1'b0;
                        r_zero      <= 1'b0;
                        r_inx       <= 1'b0;
                        r_state     <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_exp == 9'd255) begin
                        r_out_float <= {r_sign, 8'hFF, r_sig[24:2]};
                        r_state     <= S_DONE;
                    end else if (r_sig == 27'd0) begin
                        r_out_float <= 32'd0;
                        r_zero      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_sig[26]) begin
                        if (w_exp_inc >= 9'd255) begin
                            r_out_float <= {r_sign, 8'hFF, 23'd0};
                            r_ovf       <= 1'b1;
                            r_inx       <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            // Right shift folds the dropped bit into sticky
                            r_sig   <= {1'b0, r_sig[26:2], r_sig[1] | r_sig[0]};
                            r_exp   <= w_exp_inc;
                            r_state <= S_ROUND;
                        end
                    end else if (r_sig[25] || r_exp <= 9'd1) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_sig <= {r_sig[25:0], 1'b0};
                        r_exp <= r_exp - 9'd1;
                    end
                end
                S_ROUND: begin
                    r_out_float <= w_round_float;
                    r_ovf       <= w_round_ovf;
                    r_inx       <= r_sig[1] | r_sig[0];
                    r_state     <= S_DONE;
                end
                default: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE);
    assign out_float    = r_out_float;
    assign out_overflow = r_ovf;
    assign out_zero     = r_zero;
    assign out_inexact  = r_inx;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomised and directed bench for fp_normalize_round against an arithmetic
// reference model of normalise + round-to-nearest-even.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [26:0] in_sig = 27'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_float;
    logic        out_overflow;
    logic        out_zero;
    logic        out_inexact;

    fp_normalize_round dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_float(out_float), .out_overflow(out_overflow),
        .out_zero(out_zero), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] e_float = 32'd0;
    bit          e_ovf = 0, e_zero = 0, e_inx = 0;
    int          e_lat = 0;
    int          acc_cyc = 0;
    bit          prev_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: find the leading one, shift, then round the 24-bit mantissa
    task automatic model(input bit s, input bit [7:0] ei, input bit [26:0] si,
                         output logic [31:0] f, output bit ov, output bit zr,
                         output bit ix, output int lat);
        int e, msb, sh;
        longint unsigned sg, mant;
        bit g, st;
        ov = 0; zr = 0; ix = 0; f = 32'd0; lat = 1; sh = 0;
        e  = (ei == 8'd0) ? 1 : int'(ei);
        sg = 64'(si);
        if (ei == 8'hFF) begin
            f = {s, 8'hFF, si[24:2]};
            return;
        end
        if (si == 27'd0) begin
            zr = 1;
            return;
        end
        if (si[26]) begin
            if (e + 1 >= 255) begin
                f = {s, 8'hFF, 23'd0}; ov = 1; ix = 1;
                return;
            end
            sg = (sg >> 1) | (sg & 64'd1);
            e  = e + 1;
        end else begin
            msb = 0;
            for (int b = 0; b < 26; b++) if (si[b]) msb = b;
            sh = 25 - msb;
            if (sh > e - 1) sh = e - 1;
            sg = sg << sh;
            e  = e - sh;
        end
        lat  = 2 + sh;
        g    = sg[1];
        st   = sg[0];
        mant = sg >> 2;
        ix   = g | st;
        if (g && (st || mant[0])) mant = mant + 64'd1;
        if (mant >= (64'd1 << 24)) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            f = {s, 8'hFF, 23'd0}; ov = 1;
            return;
        end
        f = {s, (mant >= (64'd1 << 23)) ? 8'(e) : 8'h00, mant[22:0]};
    endtask

    // Output checker: whenever a result is presented it must match the model
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            chk("out_float", out_float, e_float);
            chk("out_overflow", 32'(out_overflow), 32'(e_ovf));
            chk("out_zero", 32'(out_zero), 32'(e_zero));
            chk("out_inexact", 32'(out_inexact), 32'(e_inx));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (!prev_valid)
                chk("latency", 32'(cyc - acc_cyc), 32'(e_lat));
        end
        prev_valid <= out_valid && !reset;
    end

    task automatic run_op(input bit s, input bit [7:0] e, input bit [26:0] sg, input int hold);
        logic [31:0] f;
        bit ov, zr, ix;
        int lat, t;
        model(s, e, sg, f, ov, zr, ix, lat);
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        e_float = f; e_ovf = ov; e_zero = zr; e_inx = ix; e_lat = lat;
        in_sign = s; in_exp = e; in_sig = sg; in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 40);
        chk("out_valid_wait", 32'(out_valid), 32'd1);
        if (!out_valid) return;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
    endtask

    task automatic directed(input bit s, input bit [7:0] e, input bit [26:0] sg,
                            input int hold, input logic [31:0] lit_f, input int lit_lat);
        logic [31:0] f;
        bit ov, zr, ix;
        int lat;
        model(s, e, sg, f, ov, zr, ix, lat);
        chk("model_float", f, lit_f);
        chk("model_latency", 32'(lat), 32'(lit_lat));
        run_op(s, e, sg, hold);
    endtask

    initial begin
        bit s;
        bit [7:0] e;
        bit [26:0] sg;
        int r;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_float", out_float, 32'd0);
        chk("rst_flags", {29'd0, out_overflow, out_zero, out_inexact}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        directed(1'b0, 8'h7F, 27'h6000000, 0, 32'h40400000, 2);
        directed(1'b0, 8'h7F, 27'h0800000, 1, 32'h3E800000, 4);
        directed(1'b1, 8'h80, 27'h0000000, 0, 32'h00000000, 1);
        directed(1'b0, 8'h7F, 27'h3FFFFFE, 2, 32'h40000000, 2);
        directed(1'b0, 8'hFE, 27'h4000000, 0, 32'h7F800000, 1);
        directed(1'b0, 8'h01, 27'h0400000, 0, 32'h00100000, 2);
        directed(1'b1, 8'hFF, 27'h0000008, 0, 32'hFF800002, 1);
        directed(1'b0, 8'h7F, 27'h2000000, 5, 32'h3F800000, 2);

        // Reset in the middle of normalising the cancellation case
        in_sign = 1'b0; in_exp = 8'h7F; in_sig = 27'h0800000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_float", out_float, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        directed(1'b0, 8'h7F, 27'h0800000, 0, 32'h3E800000, 4);

        for (int i = 0; i < 300; i++) begin
            s = 1'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0: e = 8'd0;
                1: e = 8'd1;
                2: e = 8'hFF;
                3: e = 8'hFE;
                4: e = 8'($urandom_range(2, 30));
                default: e = 8'($urandom_range(1, 254));
            endcase
            sg = 27'($urandom) >> $urandom_range(0, 27);
            run_op(s, e, sg, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
